// File: rtl/res_arb_if.sv
// Request/grant bundle between requesters and res_arbiter_4.
// The arbiter uses the slave modport and drives grants; requesters use master.
interface res_arb_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       idle;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  idle,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output idle,
    output timeout
  );
endinterface

// File: rtl/res_arbiter_4.sv
// res_arbiter_4: four-requester arbiter for one shared resource.
// Registered one-hot grant held until the owner releases, one-cycle
// turnaround gap after every grant, and an optional hold timeout (MAX_HOLD).
// After a timeout the revoked owner is masked out of the next decision only.
// Optional feature macro: RES_ARB_ROUND_ROBIN_EN selects round-robin search
// starting after the previous winner; default build is fixed priority
// (highest index wins).
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no grant; arbitrates on every edge
// S_GRANT | one owner holds gnt; counts hold cycles
// S_GAP   | single turnaround cycle, gnt low, then S_IDLE
module res_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic     clk,
  input logic     rst,
  res_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  state_t            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        id_q, id_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        mask_q, mask_d;
  logic              to_q, to_d;
  logic [3:0]        cand;
  logic [1:0]        win;

`ifdef RES_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_q, rr_d;

  // Nearest set bit above ptr (with wrap) wins; far candidates are
  // overwritten by nearer ones as the loop walks inward.
  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] ptr);
    logic [1:0] res;
    logic [1:0] idx;
    res = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (v[idx]) res = idx;
    end
    return res;
  endfunction
`else
  function automatic logic [1:0] pick(input logic [3:0] v);
    logic [1:0] res;
    if (v[3])      res = 2'd3;
    else if (v[2]) res = 2'd2;
    else if (v[1]) res = 2'd1;
    else           res = 2'd0;
    return res;
  endfunction
`endif

  // Candidate vector: masked requests, falling back to raw requests if the
  // mask would leave nobody to serve.
  always_comb begin
    cand = bus.req & ~mask_q;
    if (cand == 4'b0000) cand = bus.req;
`ifdef RES_ARB_ROUND_ROBIN_EN
    win = pick(cand, rr_q);
`else
    win = pick(cand);
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    to_d    = 1'b0;
`ifdef RES_ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cand != 4'b0000) begin
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          cnt_d   = '0;
          mask_d  = 4'b0000;
          state_d = S_GRANT;
`ifdef RES_ARB_ROUND_ROBIN_EN
          rr_d    = win;
`endif
        end
      end
      S_GRANT: begin
        if (!bus.req[id_q]) begin
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          state_d = S_GAP;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)) begin
          gnt_d   = 4'b0000;
          id_d    = 2'd0;
          to_d    = 1'b1;
          mask_d  = gnt_q;
          state_d = S_GAP;
        end else if (cnt_q != HOLD_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        id_d    = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      id_q    <= 2'd0;
      cnt_q   <= '0;
      mask_q  <= 4'b0000;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      to_q    <= to_d;
    end
  end

`ifdef RES_ARB_ROUND_ROBIN_EN
  // Round-robin pointer remembers the last winner.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 2'd3;
    else     rr_q <= rr_d;
  end
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.idle      = (state_q == S_IDLE);
  assign bus.timeout   = to_q;

endmodule
